// File: rtl/fifo_controller_if.sv
// Bundle between the FIFO controller, its upstream/downstream users and RAM_memory.
// slave = controller side, master = everything driving the controller.
interface fifo_controller_if #(
  parameter int MAIN_QUEUE_SIZE = 6,
  parameter int DATA_SIZE       = 2
);
  logic                       init;
  logic [DATA_SIZE:0]         umbral_af;
  logic [DATA_SIZE:0]         umbral_ae;
  logic                       push;
  logic [MAIN_QUEUE_SIZE-1:0] data_in;
  logic                       pop;
  logic [MAIN_QUEUE_SIZE-1:0] ram_data_out;
  logic                       ram_write;
  logic                       ram_read;
  logic [DATA_SIZE-1:0]       wr_ptr;
  logic [DATA_SIZE-1:0]       rd_ptr;
  logic [MAIN_QUEUE_SIZE-1:0] ram_data_in;
  logic [MAIN_QUEUE_SIZE-1:0] data_out;
  logic                       valid_out;
  logic [DATA_SIZE:0]         count;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic                       error;
  logic [2:0]                 state;

  modport slave (
    input  init, umbral_af, umbral_ae, push, data_in, pop, ram_data_out,
    output ram_write, ram_read, wr_ptr, rd_ptr, ram_data_in, data_out, valid_out,
           count, full, empty, almost_full, almost_empty, error, state
  );

  modport master (
    output init, umbral_af, umbral_ae, push, data_in, pop, ram_data_out,
    input  ram_write, ram_read, wr_ptr, rd_ptr, ram_data_in, data_out, valid_out,
           count, full, empty, almost_full, almost_empty, error, state
  );
endinterface

// File: rtl/fifo_controller.sv
// FIFO control around an external RAM: pointers, occupancy, threshold flags,
// threshold-load INIT phase and a sticky ERROR state on overflow/underflow.
module fifo_controller #(
  parameter int MAIN_QUEUE_SIZE = 6,
  parameter int DATA_SIZE       = 2
) (
  input  logic              clk,
  input  logic              reset,
  fifo_controller_if.slave  bus
);

  localparam int DEPTH = 2 ** DATA_SIZE;
  localparam logic [DATA_SIZE:0]   CNT_FULL = (DATA_SIZE+1)'(DEPTH);
  localparam logic [DATA_SIZE:0]   CNT_ONE  = (DATA_SIZE+1)'(1);
  localparam logic [DATA_SIZE-1:0] PTR_ONE  = DATA_SIZE'(1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DATA_SIZE-1:0] wr_ptr_q, rd_ptr_q;
  logic [DATA_SIZE:0]   count_q, count_d;
  logic [DATA_SIZE:0]   thr_af_q, thr_ae_q;
  logic                 valid_q, error_q;

  logic full, empty, op, push_ok, pop_ok, violation;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign op    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

  // Full/empty come from the registered count, so a simultaneous push+pop on a
  // full (or empty) FIFO accepts one side and flags the other as a violation.
  assign push_ok   = op && bus.push && !full;
  assign pop_ok    = op && bus.pop  && !empty;
  assign violation = op && ((bus.push && full) || (bus.pop && empty));

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  if (!bus.init) state_d = ST_IDLE;
      ST_IDLE, ST_ACTIVE: begin
        if (violation)                                state_d = ST_ERROR;
        else if (bus.init)                            state_d = ST_INIT;
        else if (state_q == ST_IDLE && push_ok)       state_d = ST_ACTIVE;
        else if (state_q == ST_ACTIVE && count_d == '0) state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RESET;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      thr_af_q <= '0;
      thr_ae_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= pop_ok;
      if (push_ok)   wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)    rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (violation) error_q  <= 1'b1;
      if (state_q == ST_INIT && bus.init) begin
        thr_af_q <= bus.umbral_af;
        thr_ae_q <= bus.umbral_ae;
      end
    end
  end

  assign bus.ram_write    = push_ok;
  assign bus.ram_read     = pop_ok;
  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_ptr       = rd_ptr_q;
  assign bus.ram_data_in  = bus.data_in;
  assign bus.data_out     = bus.ram_data_out;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= thr_af_q);
  assign bus.almost_empty = (count_q <= thr_ae_q);
  assign bus.error        = error_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_fifo_controller.sv
// Random + directed stimulus against a queue-based reference of the FIFO;
// popped words are scoreboarded and checked by an independent monitor.
module tb_fifo_controller;
  localparam int W     = 6;
  localparam int DS    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_controller_if #(.MAIN_QUEUE_SIZE(W), .DATA_SIZE(DS)) bus();
  fifo_controller #(.MAIN_QUEUE_SIZE(W), .DATA_SIZE(DS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // RAM_memory stand-in: registered read gives the one-cycle pop latency.
  logic [W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_write) mem[bus.wr_ptr] <= bus.ram_data_in;
    if (bus.ram_read)  bus.ram_data_out <= mem[bus.rd_ptr];
  end

  // Reference model: contents as a queue, state as the spec's numeric codes.
  logic [W-1:0] mq[$];
  logic [W-1:0] sb[$];
  int m_state = 0, thr_af = 0, thr_ae = 0, wr_n = 0, rd_n = 0;
  bit m_err = 1'b0;
  int u_af = 0, u_ae = 0;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.valid_out) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL valid_out_unexpected: got valid_out=1 expected no pending pop (t=%0t)", $time);
      end else begin
        chk("data_out", int'(bus.data_out), int'(sb.pop_front()));
      end
    end
  end

  task automatic step(bit rst, bit ini, bit psh, bit pp, logic [W-1:0] d);
    bit op, pok, qok, viol;
    int n;
    reset = rst;
    bus.init = ini;
    bus.umbral_af = (DS+1)'(u_af);
    bus.umbral_ae = (DS+1)'(u_ae);
    bus.push = psh;
    bus.pop = pp;
    bus.data_in = d;
    n    = mq.size();
    op   = (m_state == 2) || (m_state == 3);
    pok  = op && psh && (n < DEPTH);
    qok  = op && pp && (n > 0);
    viol = op && ((psh && n == DEPTH) || (pp && n == 0));
    #1;
    chk("ram_write", int'(bus.ram_write), int'(pok));
    chk("ram_read", int'(bus.ram_read), int'(qok));
    if (pok) chk("ram_data_in", int'(bus.ram_data_in), int'(d));
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete(); sb.delete();
      m_state = 0; thr_af = 0; thr_ae = 0; m_err = 1'b0; wr_n = 0; rd_n = 0;
    end else begin
      if (qok) begin sb.push_back(mq.pop_front()); rd_n++; end
      if (pok) begin mq.push_back(d); wr_n++; end
      case (m_state)
        0: m_state = 1;
        1: begin
          if (ini) begin thr_af = u_af; thr_ae = u_ae; end
          else m_state = 2;
        end
        2, 3: begin
          if (viol) begin m_state = 4; m_err = 1'b1; end
          else if (ini) m_state = 1;
          else if (m_state == 2 && pok) m_state = 3;
          else if (m_state == 3 && mq.size() == 0) m_state = 2;
        end
        default: ;
      endcase
    end
    @(negedge clk);
    n = mq.size();
    chk("count", int'(bus.count), n);
    chk("full", int'(bus.full), int'(n == DEPTH));
    chk("empty", int'(bus.empty), int'(n == 0));
    chk("almost_full", int'(bus.almost_full), int'(n >= thr_af));
    chk("almost_empty", int'(bus.almost_empty), int'(n <= thr_ae));
    chk("error", int'(bus.error), int'(m_err));
    chk("state", int'(bus.state), m_state);
    chk("wr_ptr", int'(bus.wr_ptr), wr_n % DEPTH);
    chk("rd_ptr", int'(bus.rd_ptr), rd_n % DEPTH);
  endtask

  task automatic reset_init(int af, int ae);
    u_af = af; u_ae = ae;
    step(1, 0, 0, 0, '0); step(1, 0, 0, 0, '0);
    step(0, 1, 0, 0, '0); step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
  endtask

  initial begin
    // Reset, threshold load, IDLE
    reset_init(3, 1);
    // Fill to full with pointer wrap
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 0, W'(i));
    // Drain in order
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, '0);
    step(0, 0, 0, 0, '0);
    // Simultaneous push+pop at count 2
    step(0, 0, 1, 0, 6'h0a); step(0, 0, 1, 0, 6'h0b);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, W'(6'h20 + i));
    step(0, 0, 0, 1, '0); step(0, 0, 0, 1, '0); step(0, 0, 0, 0, '0);
    // Overflow -> sticky ERROR
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, W'(6'h30 + i));
    step(0, 0, 1, 0, 6'h3f);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, W'(i));
    // Underflow -> sticky ERROR
    reset_init(2, 2);
    step(0, 0, 0, 1, '0);
    step(0, 0, 1, 0, 6'h11); step(0, 0, 0, 0, '0);
    // Reset mid-operation with count 3 and a pop in flight
    reset_init(3, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, W'(6'h15 + i));
    step(0, 0, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    chk("valid_out_after_reset", int'(bus.valid_out), 0);
    // Init re-entry from ACTIVE keeps contents
    reset_init(3, 1);
    step(0, 0, 1, 0, 6'h2a); step(0, 0, 1, 0, 6'h2b);
    u_af = 1; u_ae = 3;
    step(0, 1, 0, 0, '0); step(0, 1, 0, 0, '0); step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, '0); step(0, 0, 0, 1, '0); step(0, 0, 0, 0, '0);
    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      reset_init($urandom_range(0, 7), $urandom_range(0, 7));
      for (int k = 0; k < 150; k++) begin
        bit psh, pp, ini;
        if (m_state == 4 && k > 5) break;
        psh = (mq.size() == DEPTH) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1);
        pp  = (mq.size() == 0)     ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1);
        ini = ($urandom_range(0, 24) == 0);
        if (ini) begin u_af = $urandom_range(0, 7); u_ae = $urandom_range(0, 7); end
        step(0, ini, psh, pp, W'($urandom_range(0, 63)));
      end
    end
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
